// File: rtl/j1_io_ctrl_pkg.sv
// Purpose: shared state encodings, slot-field position and abort data for the j1 I/O controller.
// Latency: none; this file holds only types and constants.
// Backpressure: none.
package j1_io_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } io_state_t;

    // The slot index is the top nibble of io_addr. The low 12 bits go to the peripheral.
    localparam int SLOT_HI = 15;
    localparam int SLOT_LO = 12;
    localparam int SLOT_W  = SLOT_HI - SLOT_LO + 1;

    // Returned to the CPU on a read that is unmapped or that timed out.
    localparam logic [15:0] IO_BAD_DATA = 16'hDEAD;

endpackage

// File: rtl/j1_io_ctrl_if.sv
// Purpose: bundles the j1 CPU I/O strobes and the peripheral slot bus.
// Latency: none; this file holds wiring only.
// Backpressure: the CPU stalls while pause=1. A slot holds the access by withholding per_ack.
// Modports: master = the controller. slave = the environment, which is the CPU plus the slots.
interface j1_io_ctrl_if #(parameter int NSLOT = 4);
    logic                  io_rd;
    logic                  io_wr;
    logic [15:0]           io_addr;
    logic [15:0]           io_dout;
    logic [15:0]           io_din;
    logic                  pause;
    logic [NSLOT-1:0]      per_sel;
    logic                  per_wr;
    logic [11:0]           per_addr;
    logic [15:0]           per_wdata;
    logic [NSLOT*16-1:0]   per_rdata;
    logic [NSLOT-1:0]      per_ack;

    modport master (
        input  io_rd, io_wr, io_addr, io_dout, per_rdata, per_ack,
        output io_din, pause, per_sel, per_wr, per_addr, per_wdata
    );

    modport slave (
        output io_rd, io_wr, io_addr, io_dout, per_rdata, per_ack,
        input  io_din, pause, per_sel, per_wr, per_addr, per_wdata
    );
endinterface

// File: rtl/io_slot_decode.sv
// Purpose: converts the slot field of io_addr to a one-hot slot select and a mapped flag.
// Latency: combinational.
// Backpressure: none.
// Ports: i_slot = io_addr slot field; o_sel = one-hot slot select; o_mapped = 1 when i_slot < NSLOT.
module io_slot_decode
    import j1_io_ctrl_pkg::*;
#(
    parameter int NSLOT = 4
) (
    input  logic [SLOT_W-1:0] i_slot,
    output logic [NSLOT-1:0]  o_sel,
    output logic              o_mapped
);

    always_comb begin
        o_sel = '0;
        for (int k = 0; k < NSLOT; k++) begin
            if (i_slot == k[SLOT_W-1:0]) begin
                o_sel[k] = 1'b1;
            end
        end
        o_mapped = |o_sel;
    end

endmodule

// File: rtl/j1_io_ctrl.sv
// Purpose: sequences one select/ack handshake per j1 I/O access and logs the first faulting address.
// Latency: an ack in the first WAIT cycle gives 2 pause cycles. Each extra wait cycle adds 1. An unmapped access gives 1.
// Backpressure: pause stalls the CPU until the slot acks, the access times out, or the address is unmapped.
// Ports: sys_clk_i/sys_rst_i = clock and async active-high reset; bus = CPU and slot bus (master side);
//        err_clr_i = clear the sticky error; err_o/err_addr_o = sticky error flag and first faulting address.
module j1_io_ctrl
    import j1_io_ctrl_pkg::*;
#(
    parameter int NSLOT   = 4,
    parameter int TIMEOUT = 15
) (
    input  logic                sys_clk_i,
    input  logic                sys_rst_i,
    j1_io_ctrl_if.master        bus,
    input  logic                err_clr_i,
    output logic                err_o,
    output logic [15:0]         err_addr_o
);

    // Use at least one bit so that TIMEOUT=0 (timeout disabled) still elaborates.
    localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    io_state_t          r_state;
    logic [NSLOT-1:0]   r_sel;
    logic               r_wr;
    logic [15:0]        r_addr;
    logic [15:0]        r_wdata;
    logic [15:0]        r_din;
    logic [CW-1:0]      r_cnt;
    logic               r_err;
    logic [15:0]        r_err_addr;

    logic               w_req;
    logic [NSLOT-1:0]   w_slot_sel;
    logic               w_mapped;
    logic               w_ack;
    logic               w_tmo;
    logic [15:0]        w_rdata;
    logic               w_err_set;
    logic [15:0]        w_err_addr;

    io_slot_decode #(.NSLOT(NSLOT)) u_decode (
        .i_slot   (bus.io_addr[SLOT_HI:SLOT_LO]),
        .o_sel    (w_slot_sel),
        .o_mapped (w_mapped)
    );

    // A simultaneous rd and wr is handled as a write.
    assign w_req = bus.io_rd | bus.io_wr;

    // Only the selected slot's ack is seen. Acks from other slots are masked out.
    assign w_ack = |(bus.per_ack & r_sel);

    // This is the last WAIT cycle: the counter would reach TIMEOUT on this edge.
    assign w_tmo = (TIMEOUT != 0) && (r_cnt == CW'(TIMEOUT - 1));

    always_comb begin
        w_rdata = '0;
        for (int k = 0; k < NSLOT; k++) begin
            if (r_sel[k]) begin
                w_rdata = w_rdata | bus.per_rdata[16*k +: 16];
            end
        end
    end

    // An error is raised by an unmapped request in IDLE, or by a timeout without ack in WAIT.
    assign w_err_set  = ((r_state == ST_IDLE) && w_req && !w_mapped) ||
                        ((r_state == ST_WAIT) && !w_ack && w_tmo);
    assign w_err_addr = (r_state == ST_IDLE) ? bus.io_addr : r_addr;

    // pause must rise in the request cycle itself, so it is decoded from the state rather than registered.
    // Gating with the reset drops it at once when a reset arrives mid-access.
    assign bus.pause     = !sys_rst_i &&
                           ((r_state == ST_WAIT) || ((r_state == ST_IDLE) && w_req));
    assign bus.per_sel   = r_sel;
    assign bus.per_wr    = r_wr;
    assign bus.per_addr  = r_addr[11:0];
    assign bus.per_wdata = r_wdata;
    assign bus.io_din    = r_din;
    assign err_o         = r_err;
    assign err_addr_o    = r_err_addr;

    always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
        if (sys_rst_i) begin
            r_state    <= ST_IDLE;
            r_sel      <= '0;
            r_wr       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_din      <= '0;
            r_cnt      <= '0;
            r_err      <= 1'b0;
            r_err_addr <= '0;
        end else begin
            // A new error wins over a clear. The address is overwritten only when no error is
            // already held, or when the held one is being cleared on this same edge.
            if (w_err_set) begin
                r_err <= 1'b1;
                if (!r_err || err_clr_i) begin
                    r_err_addr <= w_err_addr;
                end
            end else if (err_clr_i) begin
                r_err <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_req) begin
                        r_addr  <= bus.io_addr;
                        r_wdata <= bus.io_dout;
                        r_wr    <= bus.io_wr;
                        r_cnt   <= '0;
                        if (w_mapped) begin
                            r_sel   <= w_slot_sel;
                            r_state <= ST_WAIT;
                        end else begin
                            // An unmapped write is dropped. An unmapped read returns the marker value.
                            if (!bus.io_wr) begin
                                r_din <= IO_BAD_DATA;
                            end
                            r_state <= ST_DONE;
                        end
                    end
                end
                ST_WAIT: begin
                    r_cnt <= r_cnt + CW'(1);
                    if (w_ack) begin
                        r_sel <= '0;
                        if (!r_wr) begin
                            r_din <= w_rdata;
                        end
                        r_state <= ST_DONE;
                    end else if (w_tmo) begin
                        r_sel <= '0;
                        if (!r_wr) begin
                            r_din <= IO_BAD_DATA;
                        end
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // The CPU takes io_din on this edge. Any strobe still high here is stale.
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
